comparador_serial_ctrl: RTL and testbench

Sequenced, bit-serial magnitude comparator for unsigned K-bit operands, processed right-to-left (LSB first). It time-multiplexes one comparison cell over K clock cycles instead of instantiating K cascaded cells. It latches a pair of operands on a start request, walks the bits with an internal counter and FSM, and delivers registered mayor/igual/menor flags with a one-cycle completion pulse. It is the sequential counterpart to the combinational right-to-left iterative comparator network. It sits between a requester issuing inicio and any logic consuming the result.

---
 rtl/comparador_serial_ctrl_if.sv | 25 ++
 rtl/comparador_serial_ctrl.sv | 109 ++++++++++
 tb/tb_comparador_serial_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparador_serial_ctrl_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
// The requester drives the master side and the comparator implements the slave side.
interface comparador_serial_ctrl_if #(
  parameter int K = 8
);
  logic         inicio;
  logic         cancelar;
  logic [K-1:0] A;
  logic [K-1:0] B;
  logic         ocupado;
  logic         listo;
  logic         mayor;
  logic         igual;
  logic         menor;

  modport master (
    output inicio, cancelar, A, B,
    input  ocupado, listo, mayor, igual, menor
  );

  modport slave (
    input  inicio, cancelar, A, B,
    output ocupado, listo, mayor, igual, menor
  );
endinterface

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial (LSB-first) unsigned magnitude comparator. One comparison cell is reused
// over K cycles, and the result is delivered with a one-cycle listo pulse.
module comparador_serial_ctrl #(
  parameter int K = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  comparador_serial_ctrl_if.slave  bus
);
  localparam int CW = $clog2(K);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    COMPARA = 2'd1,
    FIN     = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [K-1:0]  sa, sb;
  logic          g, l;
  logic          g_nxt, l_nxt;
  logic [CW-1:0] cnt;
  logic          last_bit;
  logic          mayor_q, igual_q, menor_q;

  assign last_bit = (cnt == CW'(K - 1));

  // NOTE: every signal assigned in always_comb gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      REPOSO:  if (bus.inicio) state_nxt = COMPARA;
      COMPARA: begin
        if (bus.cancelar)  state_nxt = REPOSO;
        else if (last_bit) state_nxt = FIN;
      end
      FIN:     state_nxt = REPOSO;
      default: state_nxt = REPOSO;
    endcase
  end

  // A differing bit seen later (higher weight) overrides whatever lower bits decided.
  always_comb begin
    g_nxt = g;
    l_nxt = l;
    if (sa[0] && !sb[0]) begin
      g_nxt = 1'b1;
      l_nxt = 1'b0;
    end else if (!sa[0] && sb[0]) begin
      g_nxt = 1'b0;
      l_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= REPOSO;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa      <= '0;
      sb      <= '0;
      g       <= 1'b0;
      l       <= 1'b0;
      cnt     <= '0;
      mayor_q <= 1'b0;
      igual_q <= 1'b0;
      menor_q <= 1'b0;
    end else begin
      unique case (state)
        REPOSO: begin
          if (bus.inicio) begin
            sa  <= bus.A;
            sb  <= bus.B;
            g   <= 1'b0;
            l   <= 1'b0;
            cnt <= '0;
          end
        end
        COMPARA: begin
          // An abort leaves the walk untouched and the previous result visible.
          if (!bus.cancelar) begin
            g  <= g_nxt;
            l  <= l_nxt;
            sa <= sa >> 1;
            sb <= sb >> 1;
            if (last_bit) begin
              cnt     <= '0;
              mayor_q <= g_nxt;
              menor_q <= l_nxt;
              igual_q <= ~g_nxt & ~l_nxt;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ocupado = (state != REPOSO);
  assign bus.listo   = (state == FIN);
  assign bus.mayor   = mayor_q;
  assign bus.igual   = igual_q;
  assign bus.menor   = menor_q;
endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Directed-vector bench for comparador_serial_ctrl (K = 8): latency, MSB override,
// equality, ignored inicio, abort and asynchronous reset.
module tb_comparador_serial_ctrl;
  localparam int K = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  comparador_serial_ctrl_if #(.K(K)) bus ();

  comparador_serial_ctrl #(.K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [2:0] flags;
  assign flags = {bus.mayor, bus.igual, bus.menor};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses inicio for one edge, then waits a bounded number of edges for listo.
  task automatic do_run(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [2:0] fl);
    lat = -1;
    fl  = 3'bxxx;
    bus.A      = a;
    bus.B      = b;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    for (int i = 1; i <= K + 4; i++) begin
      tick();
      if (bus.listo && lat < 0) begin
        lat = i;
        fl  = flags;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.inicio = 1'b0;
    bus.cancelar = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) tick();
    n_cmp++;
    if ({bus.ocupado, bus.listo, flags} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000", {bus.ocupado, bus.listo, flags});
    end
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({bus.ocupado, bus.listo, flags} !== 5'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b expected 00000", {bus.ocupado, bus.listo, flags});
    end
  endtask

  task automatic test_basic();
    int lat, busy, pulses;
    logic [2:0] fl;
    lat = -1; busy = 0; pulses = 0; fl = 3'bxxx;
    bus.A = 8'h5A;
    bus.B = 8'h3C;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    if (bus.ocupado) busy++;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.ocupado) busy++;
      if (bus.listo) pulses++;
      if (bus.listo && lat < 0) begin
        lat = i;
        fl  = flags;
      end
    end
    n_cmp++;
    if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_cmp++;
    if (busy !== 9) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 9", busy); end
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL basic_listo_width: got %0d expected 1", pulses); end
    n_cmp++;
    if (fl !== 3'b100) begin n_err++; $display("FAIL basic_flags_5A_3C: got %b expected 100", fl); end
  endtask

  task automatic test_msb_override();
    int lat;
    logic [2:0] fl;
    do_run(8'h80, 8'h7F, lat, fl);
    n_cmp++;
    if (lat !== 8 || fl !== 3'b100) begin
      n_err++;
      $display("FAIL msb_80_7F: got lat=%0d flags=%b expected lat=8 flags=100", lat, fl);
    end
    do_run(8'h7F, 8'h80, lat, fl);
    n_cmp++;
    if (lat !== 8 || fl !== 3'b001) begin
      n_err++;
      $display("FAIL msb_7F_80: got lat=%0d flags=%b expected lat=8 flags=001", lat, fl);
    end
  endtask

  task automatic test_equal();
    int lat;
    logic [2:0] fl;
    bus.A = 8'hFF;
    bus.B = 8'hFF;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    repeat (7) tick();
    n_cmp++;
    if (flags !== 3'b001) begin
      n_err++;
      $display("FAIL equal_hold_before_msb: got %b expected 001", flags);
    end
    tick();
    n_cmp++;
    if ({bus.listo, flags} !== 4'b1010) begin
      n_err++;
      $display("FAIL equal_FF_on_msb: got %b expected 1010", {bus.listo, flags});
    end
    tick();
    do_run(8'h00, 8'h00, lat, fl);
    n_cmp++;
    if (lat !== 8 || fl !== 3'b010) begin
      n_err++;
      $display("FAIL equal_00: got lat=%0d flags=%b expected lat=8 flags=010", lat, fl);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, lat;
    logic [2:0] fl;
    logic ocup9;
    pulses = 0; lat = -1; fl = 3'bxxx; ocup9 = 1'bx;
    bus.A = 8'h01;
    bus.B = 8'h00;
    bus.inicio = 1'b1;
    tick();
    bus.A = 8'h00;
    bus.B = 8'hFF;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (bus.listo) pulses++;
      if (i == 8) fl = flags;
      if (i == 9) ocup9 = bus.ocupado;
    end
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL b2b_single_run: got %0d pulses expected 1", pulses); end
    n_cmp++;
    if (fl !== 3'b100) begin n_err++; $display("FAIL b2b_captured_flags: got %b expected 100", fl); end
    n_cmp++;
    if (ocup9 !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after_ek1: got %b expected 0", ocup9); end
    tick();
    n_cmp++;
    if (bus.ocupado !== 1'b1) begin n_err++; $display("FAIL b2b_accept_ek2: got %b expected 1", bus.ocupado); end
    bus.inicio = 1'b0;
    for (int i = 1; i <= K + 4; i++) begin
      tick();
      if (bus.listo && lat < 0) begin
        lat = i;
        fl  = flags;
      end
    end
    n_cmp++;
    if (lat !== 8 || fl !== 3'b001) begin
      n_err++;
      $display("FAIL b2b_second_run: got lat=%0d flags=%b expected lat=8 flags=001", lat, fl);
    end
  endtask

  task automatic test_cancel();
    int lat, pulses;
    logic [2:0] fl;
    pulses = 0;
    do_run(8'h10, 8'h20, lat, fl);
    n_cmp++;
    if (lat !== 8 || fl !== 3'b001) begin
      n_err++;
      $display("FAIL cancel_setup_10_20: got lat=%0d flags=%b expected lat=8 flags=001", lat, fl);
    end
    bus.A = 8'hF0;
    bus.B = 8'h0F;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    repeat (3) begin
      tick();
      if (bus.listo) pulses++;
    end
    bus.cancelar = 1'b1;
    tick();
    bus.cancelar = 1'b0;
    if (bus.listo) pulses++;
    n_cmp++;
    if ({bus.ocupado, flags} !== 4'b0001) begin
      n_err++;
      $display("FAIL cancel_after_e4: got ocupado,flags=%b expected 0001", {bus.ocupado, flags});
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL cancel_no_listo: got %0d pulses expected 0", pulses); end
    bus.A = 8'h0F;
    bus.B = 8'h0E;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    n_cmp++;
    if (bus.ocupado !== 1'b1) begin n_err++; $display("FAIL cancel_accept_e5: got %b expected 1", bus.ocupado); end
    lat = -1;
    fl  = 3'bxxx;
    for (int i = 1; i <= K + 4; i++) begin
      tick();
      if (bus.listo && lat < 0) begin
        lat = i;
        fl  = flags;
      end
    end
    n_cmp++;
    if (lat !== 8 || fl !== 3'b100) begin
      n_err++;
      $display("FAIL cancel_rerun_0F_0E: got lat=%0d flags=%b expected lat=8 flags=100", lat, fl);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [2:0] fl;
    bus.A = 8'hAA;
    bus.B = 8'h55;
    bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.ocupado, bus.listo, flags} !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset_immediate: got %b expected 00000", {bus.ocupado, bus.listo, flags});
    end
    #1;
    reset = 1'b0;
    tick();
    do_run(8'h3C, 8'h5A, lat, fl);
    n_cmp++;
    if (lat !== 8 || fl !== 3'b001) begin
      n_err++;
      $display("FAIL async_reset_rerun_3C_5A: got lat=%0d flags=%b expected lat=8 flags=001", lat, fl);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_msb_override();
    test_equal();
    test_back_to_back();
    test_cancel();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
